// File: rtl/dfe_stage_monitor.sv
// dfe_stage_monitor
//   N-stage observation block for the DFE datapath. Tracks per-stage
//   overflow/underflow activity with sticky flags and saturating counters,
//   and captures a triggered window of one stage's samples into an internal
//   buffer that can be read back by address.
//
// Ports
//   clk, rst        system clock, synchronous active-high reset
//   stage_valid     per-stage sample strobe
//   stage_data      per-stage signed sample
//   stage_ovf/unf   per-stage overflow / underflow pulses
//   cap_sel         stage to capture
//   cap_mode        00 immediate, 01 ovf|unf, 10 |data|>=cap_thr, 11 as 00
//   cap_thr         unsigned magnitude threshold
//   cap_len         samples to capture (0 or >CAP_DEPTH means CAP_DEPTH)
//   cap_arm         arm pulse, cap_abort abort pulse
//   cnt_clr         clear all counters and sticky flags
//   rd_sel          stage whose counters are read (registered)
//   rd_addr         capture buffer read address (registered)
//   cap_state       00 IDLE, 01 ARMED, 10 CAPTURE, 11 DONE
//   cap_count       samples written in the current/last capture
//   rd_data         buffer word at previous rd_addr
//   rd_ovf_cnt/unf  counters of previous rd_sel
//   sticky_ovf/unf  sticky event flags
//   cap_done        one-cycle pulse on entry to DONE
module dfe_stage_monitor #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_STAGES = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int CAP_DEPTH  = 64,
    parameter int SEL_W      = $clog2(NUM_STAGES),
    parameter int CAP_AW     = $clog2(CAP_DEPTH)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [NUM_STAGES-1:0]                  stage_valid,
    input  logic [NUM_STAGES-1:0][DATA_WIDTH-1:0]  stage_data,
    input  logic [NUM_STAGES-1:0]                  stage_ovf,
    input  logic [NUM_STAGES-1:0]                  stage_unf,
    input  logic [SEL_W-1:0]                       cap_sel,
    input  logic [1:0]                             cap_mode,
    input  logic [DATA_WIDTH-2:0]                  cap_thr,
    input  logic [CAP_AW:0]                        cap_len,
    input  logic                                   cap_arm,
    input  logic                                   cap_abort,
    input  logic                                   cnt_clr,
    input  logic [SEL_W-1:0]                       rd_sel,
    input  logic [CAP_AW-1:0]                      rd_addr,
    output logic [1:0]                             cap_state,
    output logic [CAP_AW:0]                        cap_count,
    output logic [DATA_WIDTH-1:0]                  rd_data,
    output logic [CNT_WIDTH-1:0]                   rd_ovf_cnt,
    output logic [CNT_WIDTH-1:0]                   rd_unf_cnt,
    output logic [NUM_STAGES-1:0]                  sticky_ovf,
    output logic [NUM_STAGES-1:0]                  sticky_unf,
    output logic                                   cap_done
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_ARMED   = 2'b01,
        S_CAPTURE = 2'b10,
        S_DONE    = 2'b11
    } cap_state_e;

    localparam logic [CAP_AW:0] DEPTH_L = (CAP_AW+1)'(CAP_DEPTH);
    localparam logic [CAP_AW:0] ONE_L   = (CAP_AW+1)'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // ------------------------------------------------------------------
    // Per-stage event counters and sticky flags
    // ------------------------------------------------------------------
    logic [NUM_STAGES-1:0][CNT_WIDTH-1:0] ovf_cnt;
    logic [NUM_STAGES-1:0][CNT_WIDTH-1:0] unf_cnt;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        // Clear has priority over a same-cycle event; counters stick at all-ones.
        always_ff @(posedge clk) begin
            if (rst || cnt_clr) begin
                ovf_cnt[g]    <= '0;
                unf_cnt[g]    <= '0;
                sticky_ovf[g] <= 1'b0;
                sticky_unf[g] <= 1'b0;
            end else begin
                if (stage_ovf[g]) begin
                    sticky_ovf[g] <= 1'b1;
                    if (~&ovf_cnt[g]) ovf_cnt[g] <= ovf_cnt[g] + CNT_ONE;
                end
                if (stage_unf[g]) begin
                    sticky_unf[g] <= 1'b1;
                    if (~&unf_cnt[g]) unf_cnt[g] <= unf_cnt[g] + CNT_ONE;
                end
            end
        end
    end

    // Registered counter read port; unpopulated select codes read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ovf_cnt <= '0;
            rd_unf_cnt <= '0;
        end else if (int'(rd_sel) < NUM_STAGES) begin
            rd_ovf_cnt <= ovf_cnt[rd_sel];
            rd_unf_cnt <= unf_cnt[rd_sel];
        end else begin
            rd_ovf_cnt <= '0;
            rd_unf_cnt <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Capture configuration, latched on arm
    // ------------------------------------------------------------------
    cap_state_e               state_q, state_d;
    logic [SEL_W-1:0]         sel_q;
    logic [1:0]               mode_q;
    logic [DATA_WIDTH-2:0]    thr_q;
    logic [CAP_AW:0]          len_q;
    logic [CAP_AW:0]          count_q, count_d;
    logic                     done_d;
    logic                     latch_cfg;
    logic                     wr_en;
    logic [CAP_AW-1:0]        wr_addr;

    logic [CAP_AW:0]          eff_len;
    logic [SEL_W-1:0]         sel_in;

    assign eff_len = (cap_len == '0 || cap_len > DEPTH_L) ? DEPTH_L : cap_len;
    assign sel_in  = (int'(cap_sel) < NUM_STAGES) ? cap_sel : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q  <= '0;
            mode_q <= '0;
            thr_q  <= '0;
            len_q  <= '0;
        end else if (latch_cfg) begin
            sel_q  <= sel_in;
            mode_q <= cap_mode;
            thr_q  <= cap_thr;
            len_q  <= eff_len;
        end
    end

    // ------------------------------------------------------------------
    // Selected stream and trigger condition
    // ------------------------------------------------------------------
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_evt;
    logic [DATA_WIDTH-1:0] s_neg;
    logic [DATA_WIDTH-2:0] s_mag;
    logic                  trig;

    assign s_valid = stage_valid[sel_q];
    assign s_data  = stage_data[sel_q];
    assign s_evt   = stage_ovf[sel_q] | stage_unf[sel_q];
    assign s_neg   = -s_data;

    // Magnitude fits in DATA_WIDTH-1 bits; the most negative code has no
    // positive twin, so it clamps to the largest magnitude.
    always_comb begin
        s_mag = s_data[DATA_WIDTH-2:0];
        if (s_data[DATA_WIDTH-1]) begin
            if (s_data[DATA_WIDTH-2:0] == '0) s_mag = '1;
            else                               s_mag = s_neg[DATA_WIDTH-2:0];
        end
    end

    always_comb begin
        case (mode_q)
            2'b01:   trig = s_evt;
            2'b10:   trig = (s_mag >= thr_q);
            default: trig = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Capture FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            cap_done <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            cap_done <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        done_d    = 1'b0;
        latch_cfg = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = count_q[CAP_AW-1:0];
        if (cap_abort) begin
            // Abort keeps the partial count visible for software.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (cap_arm) begin
                        latch_cfg = 1'b1;
                        count_d   = '0;
                        state_d   = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (s_valid && trig) begin
                        wr_en   = 1'b1;
                        wr_addr = '0;
                        count_d = ONE_L;
                        if (len_q == ONE_L) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_CAPTURE;
                        end
                    end
                end
                S_CAPTURE: begin
                    if (s_valid) begin
                        wr_en   = 1'b1;
                        count_d = count_q + ONE_L;
                        if (count_d == len_q) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign cap_state = state_q;
    assign cap_count = count_q;

    // ------------------------------------------------------------------
    // Capture buffer: contents are not reset, only the read register is.
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem [CAP_DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else     rd_data <= mem[rd_addr];
    end

endmodule

// File: tb/tb_dfe_stage_monitor.sv
module tb_dfe_stage_monitor;

    localparam int DW = 16;
    localparam int NS = 4;
    localparam int CW = 4;
    localparam int CD = 64;

    logic               clk = 1'b0;
    logic               rst;
    logic [NS-1:0]      stage_valid;
    logic [NS-1:0][DW-1:0] stage_data;
    logic [NS-1:0]      stage_ovf;
    logic [NS-1:0]      stage_unf;
    logic [1:0]         cap_sel;
    logic [1:0]         cap_mode;
    logic [DW-2:0]      cap_thr;
    logic [6:0]         cap_len;
    logic               cap_arm;
    logic               cap_abort;
    logic               cnt_clr;
    logic [1:0]         rd_sel;
    logic [5:0]         rd_addr;
    logic [1:0]         cap_state;
    logic [6:0]         cap_count;
    logic [DW-1:0]      rd_data;
    logic [CW-1:0]      rd_ovf_cnt;
    logic [CW-1:0]      rd_unf_cnt;
    logic [NS-1:0]      sticky_ovf;
    logic [NS-1:0]      sticky_unf;
    logic               cap_done;

    dfe_stage_monitor #(
        .DATA_WIDTH(DW), .NUM_STAGES(NS), .CNT_WIDTH(CW), .CAP_DEPTH(CD)
    ) dut (
        .clk(clk), .rst(rst),
        .stage_valid(stage_valid), .stage_data(stage_data),
        .stage_ovf(stage_ovf), .stage_unf(stage_unf),
        .cap_sel(cap_sel), .cap_mode(cap_mode), .cap_thr(cap_thr),
        .cap_len(cap_len), .cap_arm(cap_arm), .cap_abort(cap_abort),
        .cnt_clr(cnt_clr), .rd_sel(rd_sel), .rd_addr(rd_addr),
        .cap_state(cap_state), .cap_count(cap_count), .rd_data(rd_data),
        .rd_ovf_cnt(rd_ovf_cnt), .rd_unf_cnt(rd_unf_cnt),
        .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf), .cap_done(cap_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int done_seen = 0;

    always @(posedge clk) if (cap_done === 1'b1) done_seen++;

    typedef struct {
        logic          v;
        logic [DW-1:0] d;
        logic [1:0]    st;
    } thr_vec_t;

    typedef struct {
        logic [5:0]    a;
        logic [DW-1:0] e;
    } rd_vec_t;

    thr_vec_t tv[5];
    rd_vec_t  rv[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change 1 time unit after the active edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [1:0] sel, input logic [1:0] mode,
                       input logic [DW-2:0] thr, input logic [6:0] len);
        cap_sel = sel; cap_mode = mode; cap_thr = thr; cap_len = len;
        cap_arm = 1'b1;
        step();
        cap_arm = 1'b0;
    endtask

    int d0;

    initial begin
        tv[0] = '{1'b1, 16'd0,     2'b01};
        tv[1] = '{1'b1, 16'd500,   2'b01};
        tv[2] = '{1'b1, 16'hFC19,  2'b01};   // -999
        tv[3] = '{1'b1, 16'hFC18,  2'b10};   // -1000 triggers
        tv[4] = '{1'b1, 16'd7,     2'b10};
        for (int i = 0; i < 8; i++) rv[i] = '{6'(i), 16'(100 + i)};

        rst = 1'b1; stage_valid = '0; stage_data = '0; stage_ovf = '0; stage_unf = '0;
        cap_sel = '0; cap_mode = '0; cap_thr = '0; cap_len = '0;
        cap_arm = 1'b0; cap_abort = 1'b0; cnt_clr = 1'b0; rd_sel = '0; rd_addr = '0;

        // Reset state
        step(); step();
        check("rst_state", 32'(cap_state), 0);
        check("rst_count", 32'(cap_count), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        check("rst_cnts", {rd_ovf_cnt, rd_unf_cnt}, 0);
        check("rst_sticky", {sticky_ovf, sticky_unf}, 0);
        check("rst_done", 32'(cap_done), 0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("idle_state", 32'(cap_state), 0);
        check("idle_no_done", done_seen, 0);

        // Counter saturation and clear
        stage_ovf = 4'b0100;
        for (int i = 0; i < 20; i++) step();
        stage_ovf = '0; rd_sel = 2'd2;
        step();
        check("ovf_sat", 32'(rd_ovf_cnt), 15);
        check("sticky_ovf", 32'(sticky_ovf), 4'b0100);
        check("unf_zero", 32'(rd_unf_cnt), 0);
        rd_sel = 2'd1; step();
        check("ovf_other", 32'(rd_ovf_cnt), 0);
        stage_unf = 4'b1000;
        for (int i = 0; i < 3; i++) step();
        stage_unf = '0; rd_sel = 2'd3; step();
        check("unf_cnt3", 32'(rd_unf_cnt), 3);
        check("sticky_unf", 32'(sticky_unf), 4'b1000);
        cnt_clr = 1'b1; stage_ovf = 4'b0100; step();
        cnt_clr = 1'b0; stage_ovf = '0;
        check("clr_sticky", {sticky_ovf, sticky_unf}, 0);
        rd_sel = 2'd2; step();
        check("clr_cnt", 32'(rd_ovf_cnt), 0);

        // Immediate capture on stage 1, valid every other cycle
        d0 = done_seen;
        arm(2'd1, 2'b00, '0, 7'd8);
        check("imm_armed", 32'(cap_state), 1);
        check("imm_cnt0", 32'(cap_count), 0);
        cap_sel = 2'd3; cap_len = 7'd2;          // must be ignored after arm
        stage_data[0] = 16'hDEAD;
        for (int k = 0; k < 8; k++) begin
            stage_valid = 4'b0011; stage_data[1] = 16'(100 + k);
            step();
            if (k == 7) begin
                check("imm_done_state", 32'(cap_state), 3);
                check("imm_done_pulse", 32'(cap_done), 1);
            end else begin
                check("imm_capture", 32'(cap_state), 2);
            end
            stage_valid = 4'b0001;
            step();
        end
        stage_valid = '0;
        check("imm_pulse_end", 32'(cap_done), 0);
        check("imm_count", 32'(cap_count), 8);
        step(); step();
        check("imm_one_pulse", done_seen - d0, 1);
        for (int i = 0; i < 8; i++) begin
            rd_addr = rv[i].a;
            step();
            check("imm_read", 32'(rd_data), 32'(rv[i].e));
        end
        rd_addr = 6'd0; #1;
        check("rd_latency_old", 32'(rd_data), 107);
        step();
        check("rd_latency_new", 32'(rd_data), 100);

        // Threshold trigger
        arm(2'd0, 2'b10, 15'd1000, 7'd4);
        for (int i = 0; i < 5; i++) begin
            stage_valid = {3'b000, tv[i].v}; stage_data[0] = tv[i].d;
            step();
            check("thr_state", 32'(cap_state), 32'(tv[i].st));
        end
        stage_valid = '0;
        check("thr_count", 32'(cap_count), 2);
        rd_addr = 6'd0; step();
        check("thr_addr0", 32'(rd_data), 32'hFC18);
        rd_addr = 6'd1; step();
        check("thr_addr1", 32'(rd_data), 7);
        cap_abort = 1'b1; step(); cap_abort = 1'b0;
        check("thr_abort", {cap_state, 7'(cap_count)}, {2'b00, 7'd2});
        arm(2'd0, 2'b10, 15'h7FFF, 7'd4);
        stage_valid = 4'b0001; stage_data[0] = 16'h7FFE; step();
        check("thr_max_below", 32'(cap_state), 1);
        stage_data[0] = 16'h8000; step();
        check("thr_min_neg", 32'(cap_state), 2);
        stage_valid = '0; rd_addr = 6'd0; step();
        check("thr_min_data", 32'(rd_data), 32'h8000);
        cap_abort = 1'b1; step(); cap_abort = 1'b0;

        // Overflow trigger and abort
        d0 = done_seen;
        arm(2'd2, 2'b01, '0, 7'd8);
        stage_valid = 4'b1111; stage_data[2] = 16'd200;
        stage_ovf = 4'b0001; step();
        check("ovf_other_stage", 32'(cap_state), 1);
        stage_ovf = '0; step();
        check("ovf_no_event", 32'(cap_state), 1);
        stage_ovf = 4'b0100; step();
        stage_ovf = '0;
        check("ovf_trig", {cap_state, 7'(cap_count)}, {2'b10, 7'd1});
        step(); step();
        check("ovf_three", 32'(cap_count), 3);
        cap_abort = 1'b1; cap_arm = 1'b1; step();
        cap_abort = 1'b0; cap_arm = 1'b0; stage_valid = '0;
        check("abort_state", {cap_state, 7'(cap_count)}, {2'b00, 7'd3});
        check("abort_no_done", 32'(cap_done), 0);
        step();
        check("abort_no_pulse", done_seen - d0, 0);

        // Full-depth capture with arm during capture ignored
        d0 = done_seen;
        arm(2'd3, 2'b00, '0, 7'd0);
        for (int i = 0; i < 64; i++) begin
            stage_valid = 4'b1000; stage_data[3] = 16'(i);
            if (i == 10) begin cap_arm = 1'b1; cap_sel = 2'd1; end
            step();
            cap_arm = 1'b0;
            if (i == 11) check("arm_in_capture", {cap_state, 7'(cap_count)}, {2'b10, 7'd12});
            if (i == 62) check("len0_63", {cap_state, 7'(cap_count)}, {2'b10, 7'd63});
        end
        stage_valid = '0;
        check("len0_done", {cap_state, 7'(cap_count)}, {2'b11, 7'd64});
        rd_addr = 6'd63; step();
        check("len0_last", 32'(rd_data), 63);

        // Re-arm from DONE with length 1 on another stage
        arm(2'd1, 2'b00, '0, 7'd1);
        check("rearm", {cap_state, 7'(cap_count)}, {2'b01, 7'd0});
        stage_valid = 4'b1000; step();
        check("len1_wrong_stage", 32'(cap_state), 1);
        stage_valid = 4'b0010; stage_data[1] = 16'd555; step();
        stage_valid = '0;
        check("len1_done", {cap_state, 7'(cap_count)}, {2'b11, 7'd1});
        check("len1_pulse", 32'(cap_done), 1);
        rd_addr = 6'd0; step();
        check("len1_data", 32'(rd_data), 555);
        check("len_pulses", done_seen - d0, 2);

        // Reset in the middle of a capture
        arm(2'd0, 2'b00, '0, 7'd8);
        stage_valid = 4'b0001; step(); step();
        rst = 1'b1; step(); rst = 1'b0; stage_valid = '0;
        check("rst_mid", {cap_state, 7'(cap_count)}, {2'b00, 7'd0});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
